alu_controlador: RTL and testbench

Sequencing front end for the lab ALU: accepts an operation request (operands plus opcode), drives the ALU operand and selector inputs from registers, waits a fixed settle time, then captures result and flags into output registers with a one-cycle valid pulse. It sits between the board input logic (switches/buttons) and the ALU, and is the initiator side of the ALU's `entrada1/entrada2/selector → resultado/carry/cero` interface. A sweep mode issues every defined opcode (0001–1010) on one operand pair for bring-up and regression.

---
 rtl/alu_controlador.sv | 150 +++++++++++++++
 tb/tb_alu_controlador.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_controlador.sv
// Sequencer between the board inputs and the lab ALU: registers operands and opcode,
// waits a settle time, then captures result and flags with a one-cycle valid pulse.
module alu_controlador #(
  parameter int n      = 4,
  parameter int ESPERA = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic         barrido,
  input  logic         cancelar,
  input  logic [n-1:0] op_a,
  input  logic [n-1:0] op_b,
  input  logic [3:0]   op_sel,
  output logic         listo,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [3:0]   alu_resultado,
  input  logic         alu_carry,
  input  logic         alu_cero,
  output logic [3:0]   resultado,
  output logic         carry,
  output logic         cero,
  output logic [3:0]   op_actual,
  output logic         valido,
  output logic         error
);

  localparam int            CW          = $clog2(ESPERA) + 1;
  localparam logic [CW-1:0] CNT_INI     = CW'(ESPERA - 1);
  localparam logic          S_REPOSO    = 1'b0;
  localparam logic          S_ESPERA    = 1'b1;
  localparam logic [3:0]    SEL_PRIMERO = 4'b0001;
  localparam logic [3:0]    SEL_ULTIMO  = 4'b1010;

  logic          estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          barrido_q, barrido_d;
  logic [n-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic [3:0]    resultado_q, resultado_d;
  logic          carry_q, carry_d, cero_q, cero_d;
  logic [3:0]    op_actual_q, op_actual_d;
  logic          valido_q, valido_d, error_q, error_d;
  logic          op_indefinido;

  assign op_indefinido = (op_sel == 4'b0000) || (op_sel > SEL_ULTIMO);

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    barrido_d   = barrido_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    resultado_d = resultado_q;
    carry_d     = carry_q;
    cero_d      = cero_q;
    op_actual_d = op_actual_q;
    valido_d    = 1'b0;
    error_d     = 1'b0;
    if (estado_q == S_REPOSO) begin
      if (inicio) begin
        alu_a_d   = op_a;
        alu_b_d   = op_b;
        barrido_d = barrido;
        if (barrido) begin
          alu_sel_d = SEL_PRIMERO;
          cnt_d     = CNT_INI;
          estado_d  = S_ESPERA;
        end else begin
          alu_sel_d = op_sel;
          if (op_indefinido) begin
            // Undefined opcode: report immediately without involving the ALU.
            resultado_d = 4'b0000;
            carry_d     = 1'b0;
            cero_d      = 1'b0;
            op_actual_d = op_sel;
            valido_d    = 1'b1;
            error_d     = 1'b1;
          end else begin
            cnt_d    = CNT_INI;
            estado_d = S_ESPERA;
          end
        end
      end
    end else begin
      if (cancelar) begin
        estado_d = S_REPOSO;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        resultado_d = alu_resultado;
        carry_d     = alu_carry;
        cero_d      = alu_cero;
        op_actual_d = alu_sel_q;
        valido_d    = 1'b1;
        if (!barrido_q || alu_sel_q == SEL_ULTIMO) begin
          estado_d = S_REPOSO;
        end else begin
          alu_sel_d = alu_sel_q + 4'b0001;
          cnt_d     = CNT_INI;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= S_REPOSO;
      cnt_q       <= '0;
      barrido_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 4'b0000;
      resultado_q <= 4'b0000;
      carry_q     <= 1'b0;
      cero_q      <= 1'b0;
      op_actual_q <= 4'b0000;
      valido_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      barrido_q   <= barrido_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      resultado_q <= resultado_d;
      carry_q     <= carry_d;
      cero_q      <= cero_d;
      op_actual_q <= op_actual_d;
      valido_q    <= valido_d;
      error_q     <= error_d;
    end
  end

  assign listo     = (estado_q == S_REPOSO);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign resultado = resultado_q;
  assign carry     = carry_q;
  assign cero      = cero_q;
  assign op_actual = op_actual_q;
  assign valido    = valido_q;
  assign error     = error_q;

endmodule

// File: tb/tb_alu_controlador.sv
// Directed bench: three controllers (settle 1, 3, 4) share stimulus, each driving its own ALU model.
module tb_alu_controlador;

  logic       clk = 1'b0;
  logic       rst, inicio, barrido, cancelar;
  logic [3:0] op_a, op_b, op_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // {carry, resultado}; carry is the add carry-out or the subtract borrow.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [4:0] r;
    case (s)
      4'd1:    r = {1'b0, a} + {1'b0, b};
      4'd2:    r = {1'b0, a} - {1'b0, b};
      4'd3:    r = {1'b0, a & b};
      4'd4:    r = {1'b0, a | b};
      4'd5:    r = {1'b0, a ^ b};
      4'd6:    r = {1'b0, ~a};
      4'd7:    r = {1'b0, a};
      4'd8:    r = {1'b0, b};
      4'd9:    r = {1'b0, a << 1};
      4'd10:   r = {1'b0, a >> 1};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  logic       listo1, valido1, error1, carry1, cero1, ac1, az1;
  logic [3:0] a1, b1, s1, res1, opa1, ar1;
  logic       listo3, valido3, error3, carry3, cero3, ac3, az3;
  logic [3:0] a3, b3, s3, res3, opa3, ar3;
  logic       listo4, valido4, error4, carry4, cero4, ac4, az4;
  logic [3:0] a4, b4, s4, res4, opa4, ar4;

  assign {ac1, ar1} = alu_f(a1, b1, s1);
  assign az1 = (ar1 == 4'b0);
  assign {ac3, ar3} = alu_f(a3, b3, s3);
  assign az3 = (ar3 == 4'b0);
  assign {ac4, ar4} = alu_f(a4, b4, s4);
  assign az4 = (ar4 == 4'b0);

  alu_controlador #(.n(4), .ESPERA(1)) u1 (
    .clk(clk), .rst(rst), .inicio(inicio), .barrido(barrido), .cancelar(cancelar),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .listo(listo1),
    .alu_a(a1), .alu_b(b1), .alu_sel(s1),
    .alu_resultado(ar1), .alu_carry(ac1), .alu_cero(az1),
    .resultado(res1), .carry(carry1), .cero(cero1), .op_actual(opa1),
    .valido(valido1), .error(error1));

  alu_controlador #(.n(4), .ESPERA(3)) u3 (
    .clk(clk), .rst(rst), .inicio(inicio), .barrido(barrido), .cancelar(cancelar),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .listo(listo3),
    .alu_a(a3), .alu_b(b3), .alu_sel(s3),
    .alu_resultado(ar3), .alu_carry(ac3), .alu_cero(az3),
    .resultado(res3), .carry(carry3), .cero(cero3), .op_actual(opa3),
    .valido(valido3), .error(error3));

  alu_controlador #(.n(4), .ESPERA(4)) u4 (
    .clk(clk), .rst(rst), .inicio(inicio), .barrido(barrido), .cancelar(cancelar),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .listo(listo4),
    .alu_a(a4), .alu_b(b4), .alu_sel(s4),
    .alu_resultado(ar4), .alu_carry(ac4), .alu_cero(az4),
    .resultado(res4), .carry(carry4), .cero(cero4), .op_actual(opa4),
    .valido(valido4), .error(error4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [4:0] exp_v;

  initial begin
    rst = 1'b1; inicio = 1'b0; barrido = 1'b0; cancelar = 1'b0;
    op_a = 4'd0; op_b = 4'd0; op_sel = 4'd0;
    step(); step();
    chk("rst_listo", 8'(listo1), 8'd1);
    chk("rst_valido", 8'(valido1), 8'd0);
    chk("rst_error", 8'(error1), 8'd0);
    chk("rst_alu_sel", 8'(s1), 8'd0);
    chk("rst_alu_a", 8'(a1), 8'd0);
    chk("rst_resultado", 8'(res1), 8'd0);
    chk("rst_op_actual", 8'(opa1), 8'd0);
    rst = 1'b0;

    // settle 1, single add 0111 + 0011
    op_a = 4'b0111; op_b = 4'b0011; op_sel = 4'b0001; inicio = 1'b1;
    step();
    inicio = 1'b0;
    chk("add_listo_drop", 8'(listo1), 8'd0);
    chk("add_alu_a", 8'(a1), 8'h7);
    chk("add_alu_b", 8'(b1), 8'h3);
    chk("add_early_valido", 8'(valido1), 8'd0);
    step();
    chk("add_valido", 8'(valido1), 8'd1);
    chk("add_resultado", 8'(res1), 8'b1010);
    chk("add_carry", 8'(carry1), 8'd0);
    chk("add_cero", 8'(cero1), 8'd0);
    chk("add_op_actual", 8'(opa1), 8'b0001);
    chk("add_error", 8'(error1), 8'd0);
    chk("add_listo_back", 8'(listo1), 8'd1);
    step();
    chk("add_valido_pulse", 8'(valido1), 8'd0);

    // settle 3, 1111 + 0001 with a stray request while busy
    do_reset();
    op_a = 4'b1111; op_b = 4'b0001; op_sel = 4'b0001; inicio = 1'b1;
    step();
    chk("s3_listo_drop", 8'(listo3), 8'd0);
    op_a = 4'b0010;
    step();
    inicio = 1'b0;
    chk("s3_valido_e1", 8'(valido3), 8'd0);
    step();
    chk("s3_valido_e2", 8'(valido3), 8'd0);
    step();
    chk("s3_valido", 8'(valido3), 8'd1);
    chk("s3_resultado", 8'(res3), 8'b0000);
    chk("s3_carry", 8'(carry3), 8'd1);
    chk("s3_cero", 8'(cero3), 8'd1);
    chk("s3_busy_ignored", 8'(a3), 8'hF);
    chk("s3_listo_back", 8'(listo3), 8'd1);
    step();
    chk("s3_valido_pulse", 8'(valido3), 8'd0);
    chk("s3_no_requeue", 8'(listo3), 8'd1);

    // undefined opcode
    do_reset();
    op_a = 4'b0101; op_b = 4'b0101; op_sel = 4'b1100; inicio = 1'b1;
    step();
    inicio = 1'b0;
    chk("undef_valido", 8'(valido1), 8'd1);
    chk("undef_error", 8'(error1), 8'd1);
    chk("undef_resultado", 8'(res1), 8'd0);
    chk("undef_op_actual", 8'(opa1), 8'b1100);
    chk("undef_listo", 8'(listo1), 8'd1);
    chk("undef_valido3", 8'(valido3), 8'd1);
    step();
    chk("undef_valido_pulse", 8'(valido1), 8'd0);
    chk("undef_error_pulse", 8'(error1), 8'd0);

    // opcode 0000 is also undefined
    op_sel = 4'b0000; inicio = 1'b1;
    step();
    inicio = 1'b0;
    chk("undef0_error", 8'(error1), 8'd1);

    // full sweep, settle 1
    do_reset();
    op_a = 4'b0101; op_b = 4'b0011; op_sel = 4'b1111; barrido = 1'b1; inicio = 1'b1;
    step();
    inicio = 1'b0; barrido = 1'b0;
    chk("sw_first_sel", 8'(s1), 8'b0001);
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = alu_f(4'b0101, 4'b0011, 4'(k));
      chk("sw_valido", 8'(valido1), 8'd1);
      chk("sw_op_actual", 8'(opa1), 8'(k));
      chk("sw_resultado", 8'(res1), 8'(exp_v[3:0]));
      chk("sw_carry", 8'(carry1), 8'(exp_v[4]));
      chk("sw_listo", 8'(listo1), (k == 10) ? 8'd1 : 8'd0);
    end
    step();
    chk("sw_end_valido", 8'(valido1), 8'd0);
    chk("sw_end_listo", 8'(listo1), 8'd1);

    // reset in the middle of a sweep, before the third capture
    do_reset();
    op_a = 4'b1001; op_b = 4'b0110; barrido = 1'b1; inicio = 1'b1;
    step();
    inicio = 1'b0; barrido = 1'b0;
    step();
    step();
    chk("rsw_op2", 8'(opa1), 8'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsw_valido", 8'(valido1), 8'd0);
    chk("rsw_resultado", 8'(res1), 8'd0);
    chk("rsw_op_actual", 8'(opa1), 8'd0);
    chk("rsw_alu_sel", 8'(s1), 8'd0);
    chk("rsw_alu_a", 8'(a1), 8'd0);
    chk("rsw_carry", 8'(carry1), 8'd0);
    chk("rsw_listo", 8'(listo1), 8'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rsw_quiet", 8'(valido1), 8'd0);
    end

    // settle 4, cancel on the capture edge
    do_reset();
    op_a = 4'b0011; op_b = 4'b0100; op_sel = 4'b0001; inicio = 1'b1;
    step();
    inicio = 1'b0;
    step(); step(); step();
    chk("c4_early", 8'(valido4), 8'd0);
    step();
    chk("c4_valido", 8'(valido4), 8'd1);
    chk("c4_resultado", 8'(res4), 8'b0111);
    step();
    op_a = 4'b1001; op_b = 4'b1001; op_sel = 4'b0010; inicio = 1'b1;
    step();
    inicio = 1'b0;
    chk("c4_busy", 8'(listo4), 8'd0);
    step(); step(); step();
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    chk("c4_cancel_valido", 8'(valido4), 8'd0);
    chk("c4_cancel_listo", 8'(listo4), 8'd1);
    chk("c4_kept_resultado", 8'(res4), 8'b0111);
    chk("c4_kept_op_actual", 8'(opa4), 8'b0001);
    chk("c4_kept_cero", 8'(cero4), 8'd0);
    step();
    chk("c4_after_valido", 8'(valido4), 8'd0);

    // cancel in idle does not block a coincident request
    op_a = 4'b0110; op_b = 4'b0011; op_sel = 4'b0011; inicio = 1'b1; cancelar = 1'b1;
    step();
    inicio = 1'b0; cancelar = 1'b0;
    chk("ci_accepted", 8'(listo1), 8'd0);
    step();
    chk("ci_valido", 8'(valido1), 8'd1);
    chk("ci_resultado", 8'(res1), 8'b0010);
    chk("ci_op_actual", 8'(opa1), 8'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
